// File: rtl/weight_bram_sequencer_if.sv
// weight_bram_sequencer_if
//   Groups the handshake and BRAM port signals of weight_bram_sequencer.
//   master : the sequencer side (drives wr_ready/load_done/busy/w_*/done/bram_* outputs)
//   slave  : the environment side (loader, layer FSM, neuron MAC, BRAM)
//   Loader    : wr_valid, wr_data, wr_ready, load_done
//   Control   : start, busy, done
//   Stream    : w_valid, w_data, w_idx, w_last, w_ready
//   BRAM port : bram_addr, bram_di, bram_en, bram_we, bram_do
interface weight_bram_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) ();
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              load_done;
  logic              start;
  logic              busy;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_idx;
  logic              w_last;
  logic              w_ready;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;
  logic              bram_en;
  logic              bram_we;
  logic [DATA_W-1:0] bram_do;

  modport master (
    input  wr_valid, wr_data, start, w_ready, bram_do,
    output wr_ready, load_done, busy, w_valid, w_data, w_idx, w_last, done,
           bram_addr, bram_di, bram_en, bram_we
  );

  modport slave (
    output wr_valid, wr_data, start, w_ready, bram_do,
    input  wr_ready, load_done, busy, w_valid, w_data, w_idx, w_last, done,
           bram_addr, bram_di, bram_en, bram_we
  );
endinterface

// File: rtl/weight_bram_sequencer.sv
// weight_bram_sequencer
//   Owns the single port of one DEPTH x DATA_W weight BRAM (falling-edge
//   clocked). Arbitrates between the loader writing a full row and the MAC
//   streaming a full row out through a 2-entry valid/ready buffer.
// Ports:
//   CLK  - rising-edge clock for all sequencer state
//   RST  - synchronous active-high reset
//   bus  - weight_bram_sequencer_if.master (loader, control, stream, BRAM port)
// Optional feature, macro WSEQ_CHECKSUM_EN:
//   load_sum     - mod-2^DATA_W sum of the last complete load
//   read_sum     - sum of words popped in the current/last read pass
//   sum_mismatch - read_sum != load_sum, updated at each done
module weight_bram_sequencer #(
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic CLK,
  input  logic RST,
  weight_bram_sequencer_if.master bus
`ifdef WSEQ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_sum,
  output logic [DATA_W-1:0] read_sum,
  output logic              sum_mismatch
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READ, ST_DONE} state_e;

  localparam logic [ADDR_W:0]   RD_END  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              start_pend_q, start_pend_d;
  logic              load_done_q, load_done_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [ADDR_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
  logic              wr_open, wr_acc, issue, pop;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    start_pend_d = start_pend_q;
    load_done_d  = 1'b0;
    occ_d        = occ_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    idx0_d       = idx0_q;
    idx1_d       = idx1_q;

    wr_open = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    wr_acc  = wr_open && bus.wr_valid;
    // The BRAM returns DO on the falling edge inside the issue cycle, so the
    // word is pushed on the rising edge that closes that cycle; no read is
    // ever outstanding across an edge and occupancy alone gates issue.
    issue   = (state_q == ST_READ) && (rd_ptr_q < RD_END) && (occ_q < 2'd2);
    pop     = (occ_q != 2'd0) && bus.w_ready;

    // Slot 0 is the head; a pop shifts slot 1 down before any push lands.
    if (pop) begin
      data0_d = data1_q;
      idx0_d  = idx1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (occ_d == 2'd0) begin
        data0_d = bus.bram_do;
        idx0_d  = rd_ptr_q[ADDR_W-1:0];
      end else begin
        data1_d = bus.bram_do;
        idx1_d  = rd_ptr_q[ADDR_W-1:0];
      end
      occ_d = occ_d + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.wr_valid) begin
          start_pend_d = start_pend_q | bus.start;
        end else if (bus.start || start_pend_q) begin
          state_d      = ST_READ;
          start_pend_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.start) start_pend_d = 1'b1;
      end
      ST_READ: begin
        if ((rd_ptr_q == RD_END) && (occ_d == 2'd0)) state_d = ST_DONE;
      end
      ST_DONE: begin
        rd_ptr_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_acc) begin
      if (wr_ptr_q == WR_LAST) begin
        wr_ptr_d    = '0;
        load_done_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = ST_LOAD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      start_pend_q <= 1'b0;
      load_done_q  <= 1'b0;
      occ_q        <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      idx0_q       <= '0;
      idx1_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      start_pend_q <= start_pend_d;
      load_done_q  <= load_done_d;
      occ_q        <= occ_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      idx0_q       <= idx0_d;
      idx1_q       <= idx1_d;
    end
  end

  assign bus.wr_ready  = wr_open;
  assign bus.load_done = load_done_q;
  assign bus.busy      = (state_q != ST_IDLE) || start_pend_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.w_valid   = (occ_q != 2'd0);
  assign bus.w_data    = data0_q;
  assign bus.w_idx     = idx0_q;
  assign bus.w_last    = (occ_q != 2'd0) && (idx0_q == WR_LAST);
  assign bus.bram_en   = wr_acc || issue;
  assign bus.bram_we   = wr_acc;
  assign bus.bram_addr = wr_acc ? wr_ptr_q : (issue ? rd_ptr_q[ADDR_W-1:0] : '0);
  assign bus.bram_di   = wr_acc ? bus.wr_data : '0;

`ifdef WSEQ_CHECKSUM_EN
  logic [DATA_W-1:0] load_acc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_acc_q   <= '0;
      load_sum     <= '0;
      read_sum     <= '0;
      sum_mismatch <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_ptr_q == WR_LAST) begin
          load_sum   <= load_acc_q + bus.wr_data;
          load_acc_q <= '0;
        end else begin
          load_acc_q <= load_acc_q + bus.wr_data;
        end
      end
      if ((state_q == ST_IDLE) && (state_d == ST_READ)) begin
        read_sum <= '0;
      end else if (pop) begin
        read_sum <= read_sum + data0_q;
      end
      if (state_q == ST_DONE) sum_mismatch <= (read_sum != load_sum);
    end
  end
`endif

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// tb_weight_bram_sequencer
//   Directed bench for weight_bram_sequencer with a falling-edge BRAM model.
//   The expected stream is built from the words the bench itself loaded.
//   WSEQ_CHECKSUM_EN adds the checksum scenarios.
module tb_weight_bram_sequencer;
  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  weight_bram_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef WSEQ_CHECKSUM_EN
  logic [DATA_W-1:0] load_sum, read_sum;
  logic              sum_mismatch;
`endif

  weight_bram_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef WSEQ_CHECKSUM_EN
    ,
    .load_sum(load_sum),
    .read_sum(read_sum),
    .sum_mismatch(sum_mismatch)
`endif
  );

  // BRAM: samples port on the falling edge; corrupt_addr forces DO bit0 high
  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] bram_do_r = '0;
  int                corrupt_addr = -1;
  assign bus.bram_do = bram_do_r;
  always @(negedge CLK) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_di;
      else bram_do_r <= mem[bus.bram_addr] |
                        ((int'(bus.bram_addr) == corrupt_addr) ? 16'h0001 : 16'h0000);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] word_of(input int mode, input int i);
    case (mode)
      0:       return 16'(i + 1);
      1:       return 16'h1000;
      default: return 16'hA500 ^ 16'(i * 7);
    endcase
  endfunction

  // Model: row contents as loaded, and the words a read pass must deliver
  typedef struct { logic [DATA_W-1:0] data; logic [ADDR_W-1:0] idx; } exp_t;
  logic [DATA_W-1:0] model_mem [DEPTH];
  exp_t              exp_q [$];
  int                n_issued = 0, n_popped = 0, occ_now;
  bit                in_read = 0, stalled_prev = 0;
  logic [21:0]       prev_out;
  logic [DATA_W-1:0] first_pop_data = '0, last_pop_data = '0;

  always @(negedge CLK) begin
    if (RST) begin
      n_issued     = 0;
      n_popped     = 0;
      stalled_prev = 0;
    end else begin
      occ_now = n_issued - n_popped;
      check("occupancy_le_2", occ_now <= 2, 1);
      check("w_valid_vs_occupancy", bus.w_valid, occ_now != 0);
      if (stalled_prev) check("stall_hold", {bus.w_data, bus.w_idx, bus.w_last}, prev_out);
      if (bus.w_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_w_valid", bus.w_valid, 0);
        end else begin
          check("w_data", bus.w_data, exp_q[0].data);
          check("w_idx", bus.w_idx, exp_q[0].idx);
          check("w_last", bus.w_last, exp_q[0].idx == ADDR_W'(DEPTH - 1));
          if (bus.w_ready) exp_q.delete(0);
        end
        if (bus.w_ready) begin
          n_popped++;
          if (bus.w_idx == '0) first_pop_data = bus.w_data;
          last_pop_data = bus.w_data;
        end
      end
      if (bus.bram_en && !bus.bram_we) n_issued++;
      if (in_read) check("bram_we_in_read", bus.bram_we, 0);
      stalled_prev = bus.w_valid && !bus.w_ready;
      prev_out     = {bus.w_data, bus.w_idx, bus.w_last};
    end
  end

  task automatic check_reset_outputs();
    check("reset_outputs_zero",
          {bus.w_valid, bus.w_data, bus.w_idx, bus.w_last, bus.busy, bus.done, bus.load_done,
           bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_di}, 0);
    check("reset_wr_ready", bus.wr_ready, 1);
  endtask

  // Entered and left at posedge+1
  task automatic load_row(input int mode, input bit with_start, input int gap_every);
    for (int i = 0; i < DEPTH; i++) begin
      if (gap_every != 0 && i > 0 && (i % gap_every) == 0) begin
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
        @(negedge CLK);
        check("busy_in_gap", bus.busy, 1);
        check("no_bram_access_in_gap", bus.bram_en, 0);
        @(posedge CLK); #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = word_of(mode, i);
      bus.start    = with_start && (i == 0);
      @(negedge CLK);
      check("wr_ready_load", bus.wr_ready, 1);
      check("bram_write_port", {bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_di},
            {1'b1, 1'b1, 5'(i), word_of(mode, i)});
      check("load_done_quiet", bus.load_done, 0);
      check("busy_load", bus.busy, (i > 0) ? 1 : 0);
      @(posedge CLK); #1;
      model_mem[i] = word_of(mode, i);
    end
    bus.wr_valid = 1'b0;
    bus.start    = 1'b0;
    @(negedge CLK);
    check("load_done_pulse", bus.load_done, 1);
    check("busy_after_load", bus.busy, with_start);
    @(posedge CLK); #1;
  endtask

  // ready_mode 0: always ready; 1: ready pattern 1,0,0,1 repeating
  task automatic read_pass(input bit do_start, input int ready_mode, input bit junk_wr,
                           input int abort_after);
    int   c, pops, vcnt, first_v, last_v, last_pop, done_cyc;
    bit   done_seen;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.data = model_mem[i] | ((i == corrupt_addr) ? 16'h0001 : 16'h0000);
      e.idx  = ADDR_W'(i);
      exp_q.push_back(e);
    end
    if (do_start) begin
      bus.start = 1'b1;
      @(posedge CLK); #1;
      bus.start = 1'b0;
    end
    in_read = 1;
    if (junk_wr) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'hDEAD;
    end
    c = 0; pops = 0; vcnt = 0; first_v = -1; last_v = -1; last_pop = -1; done_cyc = -1;
    done_seen = 0;
    while (!done_seen && c < 400) begin
      bus.w_ready = (ready_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      @(negedge CLK);
      check("busy_in_pass", bus.busy, 1);
      if (junk_wr) check("wr_ready_in_read", bus.wr_ready, 0);
      if (bus.w_valid) begin
        vcnt++;
        if (first_v < 0) first_v = c;
        last_v = c;
        if (bus.w_ready) begin
          pops++;
          last_pop = c;
        end
      end
      if (bus.done) begin
        done_seen = 1;
        done_cyc  = c;
      end
      @(posedge CLK); #1;
      if (abort_after != 0 && pops == abort_after) break;
      c++;
    end
    if (abort_after != 0) begin
      bus.w_ready = 1'b0;
      RST         = 1'b1;
      exp_q.delete();
      in_read     = 0;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check_reset_outputs();
      @(posedge CLK); #1;
      return;
    end
    in_read = 0;
    if (junk_wr) bus.wr_valid = 1'b0;
    check("done_seen", done_seen, 1);
    check("pops_per_pass", pops, DEPTH);
    if (ready_mode == 0) begin
      check("first_valid_latency", first_v, 1);
      check("valid_run_length", last_v - first_v + 1, DEPTH);
      check("valid_cycle_count", vcnt, DEPTH);
      check("done_after_last_pop", done_cyc, last_pop + 1);
    end
    @(negedge CLK);
    check("done_one_cycle", bus.done, 0);
    check("idle_not_busy", bus.busy, 0);
    check("idle_no_valid", bus.w_valid, 0);
    check("all_words_delivered", exp_q.size(), 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.w_ready  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs();
    @(posedge CLK); #1;

    // 0x0001..0x001C, full-rate read
    load_row(0, 0, 0);
    read_pass(1, 0, 0, 0);
    check("first_word_literal", first_pop_data, 16'h0001);
    check("last_word_literal", last_pop_data, 16'h001C);

    // stalled consumer
    read_pass(1, 1, 0, 0);

    // start together with first write: load first, then read without new start
    load_row(2, 1, 5);
    read_pass(0, 0, 0, 0);

    // loader pushing during READ must not disturb the row
    read_pass(1, 0, 1, 0);
    read_pass(1, 1, 0, 0);

    // reset after 10 pops, then a fresh pass from idx 0
    read_pass(1, 0, 0, 10);
    read_pass(1, 0, 0, 0);
    check("post_reset_first_word", first_pop_data, 16'hA500);

`ifdef WSEQ_CHECKSUM_EN
    load_row(1, 0, 0);
    check("load_sum_literal", load_sum, 16'hC000);
    read_pass(1, 0, 0, 0);
    check("read_sum_clean", read_sum, 16'hC000);
    check("sum_mismatch_clean", sum_mismatch, 0);
    corrupt_addr = 5;
    read_pass(1, 1, 0, 0);
    corrupt_addr = -1;
    check("read_sum_corrupt", read_sum, 16'hC001);
    check("sum_mismatch_corrupt", sum_mismatch, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_bram_sequencer.md
Name: weight_bram_sequencer

Overview:
- Controller owning the single port of one 28 x 16-bit weight BRAM. The BRAM has a 5-bit ADDR, 16-bit DI/DO, EN and WE, and is clocked on the falling edge.
- Arbitrates between the weight loader, which writes a full row of weights, and the neuron MAC, which streams a full row of weights out.
- Streams reads in address order through a 2-entry output buffer with valid/ready backpressure.
- Sits between the layer control FSM/loader and each neuron's weight BRAM.

Parameters:
- DEPTH, 28, number of weight words per row.
- ADDR_W, 5, BRAM address width; DEPTH <= 2^ADDR_W.
- DATA_W, 16, weight word width.

Ports:
- CLK  in  1  system clock; sequencer logic on rising edge.
- RST  in  1  synchronous active-high reset.
- wr_valid  in  1  loader offers a weight word.
- wr_data  in  DATA_W  weight word.
- wr_ready  out  1  word accepted this cycle when wr_valid & wr_ready.
- load_done  out  1  1-cycle pulse after the DEPTH-th word is written.
- start  in  1  request a full read pass; level or pulse.
- busy  out  1  high in LOAD, READ, DONE, or while a start is pending.
- w_valid  out  1  output buffer head is valid.
- w_data  out  DATA_W  weight at buffer head.
- w_idx  out  ADDR_W  address of the head word.
- w_last  out  1  head word is index DEPTH-1.
- w_ready  in  1  consumer pops the head when w_valid & w_ready.
- done  out  1  1-cycle pulse when a read pass completes.
- bram_addr  out  ADDR_W  to BRAM ADDR.
- bram_di  out  DATA_W  to BRAM DI.
- bram_en  out  1  to BRAM EN.
- bram_we  out  1  to BRAM WE.
- bram_do  in  DATA_W  from BRAM DO.

Behaviour:
- States: IDLE, LOAD, READ, DONE.
- Reset values: state IDLE, wr_ptr=0, rd_ptr=0, buffer empty, in-flight flag clear, start_pend=0. All outputs 0, except that wr_ready combinationally reflects IDLE/LOAD.
- Reset mid-pass discards any in-flight read; the next pass restarts at address 0.
- BRAM port signals are combinational from registered state plus the handshake. The BRAM samples them at the falling edge in mid-cycle. Idle value is bram_en=0, bram_we=0.
- IDLE, wr_valid=1: write word 0 this cycle and go to LOAD.
- IDLE, start=1 (or start_pend=1) and wr_valid=0: go to READ and clear start_pend.
- IDLE, wr_valid and start together: the load wins; start is latched into start_pend.
- LOAD:
  - wr_ready=1.
  - Each accepted word drives en=1, we=1, addr=wr_ptr, di=wr_data, then wr_ptr++.
  - Once DEPTH words are written: wr_ptr=0, load_done pulses, state returns to IDLE.
  - A start seen in LOAD sets start_pend. A pending start launches READ on the cycle after the return to IDLE.
  - Gaps in wr_valid are allowed.
- READ:
  - wr_ready=0.
  - Issue a read (en=1, we=0, addr=rd_ptr, then rd_ptr++) only when rd_ptr<DEPTH and occupancy + inflight < 2.
  - DO is valid at the next rising edge and is pushed into the buffer together with its index.
  - Issue-to-w_valid latency is 1 cycle.
  - With w_ready held high, one word is delivered per cycle with no bubbles after the first.
  - Buffer push and pop in the same cycle are legal; occupancy is unchanged.
  - The buffer never overflows; a bench assertion checks this.
- Transition to DONE once rd_ptr=DEPTH, inflight=0 and the buffer is empty.
- DONE lasts 1 cycle: done=1, rd_ptr=0, then IDLE. A start asserted during READ or DONE is ignored; it is not latched.
- w_data, w_idx and w_last hold stable while w_valid & !w_ready.
- w_idx counts from 0 to DEPTH-1 and wraps to 0 at the next pass.

Optional Feature:
- Macro: WSEQ_CHECKSUM_EN.
- When defined:
  - Adds output ports load_sum[DATA_W], read_sum[DATA_W] and sum_mismatch[1].
  - load_sum is the mod-2^DATA_W sum of the words written in the current LOAD, latched at load_done.
  - read_sum accumulates popped words and clears at the start of READ.
  - At done: sum_mismatch <= (read_sum_final != load_sum); the flag holds until the next done or RST.
  - RST clears all three outputs.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Load words 0x0001..0x001C with no gaps, then start with w_ready=1:
  - load_done pulses after the 28th write.
  - w_data = 0x0001..0x001C, w_idx = 0..27, w_last only on idx 27.
  - done one cycle after the last pop; 28 consecutive valid cycles.
- Read pass with w_ready toggling 1,0,0,1 repeating:
  - Every word is delivered exactly once, in order.
  - Outputs stay stable during stalls; occupancy never exceeds 2.
- wr_valid and start asserted in the same IDLE cycle:
  - 28 words are loaded first, then READ begins with no further start.
  - busy stays high throughout.
- wr_valid=1 during READ: wr_ready=0, bram_we stays 0 for the whole pass, and stored data is unchanged on the next pass.
- RST asserted after 10 words popped:
  - The next cycle shows all outputs 0 and state IDLE.
  - A new start delivers idx 0 first with correct data.
- With WSEQ_CHECKSUM_EN:
  - Load 28 x 0x1000 → load_sum=0xC000.
  - A clean read gives sum_mismatch=0.
  - Forcing bram_do bit0 high on one read gives sum_mismatch=1 at done.
